// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, address type and address helpers for the
// double-buffered framebuffer port arbiter.
package fb_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 180;
  localparam int SCALE    = 4;
  localparam int PIX_W    = 8;
  localparam int SCALE_SH = $clog2(SCALE);
  localparam int ADDR_W   = 17;

  typedef logic [ADDR_W-1:0] fb_addr_t;

  localparam fb_addr_t FB_SIZE = fb_addr_t'(FB_W * FB_H);

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Scaled-down screen coordinate -> linear address inside the selected buffer.
  function automatic fb_addr_t video_addr(input logic sel, input logic [9:0] vc,
                                          input logic [10:0] hc);
    fb_addr_t base;
    base = sel ? FB_SIZE : fb_addr_t'(0);
    return base + fb_addr_t'(vc >> SCALE_SH) * fb_addr_t'(FB_W) + fb_addr_t'(hc >> SCALE_SH);
  endfunction

  function automatic fb_addr_t client_addr(input logic front, input logic [15:0] idx);
    return (front ? fb_addr_t'(0) : FB_SIZE) + fb_addr_t'(idx);
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth, resettable shift-register delay line.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: every stage is reset (not just the tail) because the stages carry
  // valid tags; a stale tag surviving reset would emit a phantom response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Time-slices a single-port framebuffer memory between video scan-out
// (one fetch per 4 pixels) and a client port, with frame-synchronous swap.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic             clk_pixel_in,
  input  logic             rst_n_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             ad_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             nf_in,
  output logic [PIX_W-1:0] pix_out,
  output logic             ad_out,
  output logic             hs_out,
  output logic             vs_out,
  input  logic             cl_valid_in,
  input  logic             cl_we_in,
  input  logic [15:0]      cl_addr_in,
  input  logic [PIX_W-1:0] cl_wdata_in,
  output logic             cl_ready_out,
  output logic             cl_rvalid_out,
  output logic [PIX_W-1:0] cl_rdata_out,
  input  logic             swap_req_in,
  output logic             swap_done_out,
  output logic             front_sel_out,
  output fb_addr_t         mem_addr_out,
  output logic             mem_we_out,
  output logic [PIX_W-1:0] mem_wdata_out,
  input  logic [PIX_W-1:0] mem_rdata_in
);

  swap_state_t      swap_state;
  logic             front_sel;
  logic             run_q;
  logic             video_slot;
  logic             accept;
  logic             addr_oor;
  logic             pix_tag;
  logic [1:0]       rd_tag;
  logic [2:0]       sync_q;
  logic [PIX_W-1:0] pix_q;

  assign video_slot    = ad_in && (hcount_in[SCALE_SH-1:0] == '0);
  // run_q keeps the client port closed until the first edge after reset.
  assign cl_ready_out  = run_q && !video_slot;
  assign accept        = cl_valid_in && cl_ready_out;
  assign addr_oor      = fb_addr_t'(cl_addr_in) >= FB_SIZE;
  assign front_sel_out = front_sel;

  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge value of front_sel and friends regardless of statement order.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      swap_state    <= SWAP_IDLE;
      front_sel     <= 1'b0;
      swap_done_out <= 1'b0;
    end else begin
      swap_done_out <= 1'b0;
      case (swap_state)
        SWAP_IDLE: begin
          if (swap_req_in && nf_in) begin
            front_sel     <= ~front_sel;
            swap_done_out <= 1'b1;
          end else if (swap_req_in) begin
            swap_state <= SWAP_PENDING;
          end
        end
        SWAP_PENDING: begin
          if (nf_in) begin
            swap_state    <= SWAP_IDLE;
            front_sel     <= ~front_sel;
            swap_done_out <= 1'b1;
          end
        end
        default: swap_state <= SWAP_IDLE;
      endcase
    end
  end

  // Client operations latch the back buffer at acceptance time.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_addr_out  <= '0;
      mem_we_out    <= 1'b0;
      mem_wdata_out <= '0;
    end else begin
      mem_we_out <= 1'b0;
      if (video_slot) begin
        mem_addr_out <= video_addr(front_sel, vcount_in, hcount_in);
      end else if (accept) begin
        mem_addr_out  <= client_addr(front_sel, cl_addr_in);
        mem_we_out    <= cl_we_in && !addr_oor;
        mem_wdata_out <= cl_wdata_in;
      end
    end
  end

  pipe_delay #(.WIDTH(3), .DEPTH(RD_LAT + 2)) u_sync_dly (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .d({ad_in, hs_in, vs_in}), .q(sync_q)
  );

  pipe_delay #(.WIDTH(2), .DEPTH(RD_LAT + 1)) u_rd_tag (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .d({accept && !cl_we_in, addr_oor}), .q(rd_tag)
  );

  pipe_delay #(.WIDTH(1), .DEPTH(RD_LAT + 1)) u_pix_tag (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .d(video_slot), .q(pix_tag)
  );

  assign {ad_out, hs_out, vs_out} = sync_q;

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cl_rvalid_out <= 1'b0;
      cl_rdata_out  <= '0;
      pix_q         <= '0;
    end else begin
      cl_rvalid_out <= rd_tag[1];
      if (rd_tag[1]) cl_rdata_out <= rd_tag[0] ? '0 : mem_rdata_in;
      if (pix_tag)   pix_q        <= mem_rdata_in;
    end
  end

  assign pix_out = ad_out ? pix_q : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: behavioural memory with read
// latency, per-cycle reference model and a read-response scoreboard.
module tb_fb_port_arbiter;

  localparam int RD_LAT = 2;
  localparam int LAT    = RD_LAT + 2;
  localparam int FB_SZ  = 57600;

  typedef struct {
    logic       ad, hs, vs, slot;
    logic [7:0] val;
  } hist_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  logic        clk_pixel_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        ad_in, hs_in, vs_in, nf_in;
  logic [7:0]  pix_out;
  logic        ad_out, hs_out, vs_out;
  logic        cl_valid_in, cl_we_in;
  logic [15:0] cl_addr_in;
  logic [7:0]  cl_wdata_in;
  logic        cl_ready_out, cl_rvalid_out;
  logic [7:0]  cl_rdata_out;
  logic        swap_req_in, swap_done_out, front_sel_out;
  logic [16:0] mem_addr_out;
  logic        mem_we_out;
  logic [7:0]  mem_wdata_out, mem_rdata_in;

  fb_port_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk_pixel_in(clk_pixel_in), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .ad_in(ad_in), .hs_in(hs_in),
    .vs_in(vs_in), .nf_in(nf_in), .pix_out(pix_out), .ad_out(ad_out),
    .hs_out(hs_out), .vs_out(vs_out), .cl_valid_in(cl_valid_in), .cl_we_in(cl_we_in),
    .cl_addr_in(cl_addr_in), .cl_wdata_in(cl_wdata_in), .cl_ready_out(cl_ready_out),
    .cl_rvalid_out(cl_rvalid_out), .cl_rdata_out(cl_rdata_out),
    .swap_req_in(swap_req_in), .swap_done_out(swap_done_out),
    .front_sel_out(front_sel_out), .mem_addr_out(mem_addr_out),
    .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
  );

  always #5 clk_pixel_in = ~clk_pixel_in;

  // Behavioural single-port memory: address sampled at the edge, data RD_LAT later.
  logic [7:0] mem [131072];
  logic [7:0] dp  [RD_LAT];

  always @(posedge clk_pixel_in) begin
    if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
    dp[0] <= mem[mem_addr_out];
    for (int i = 1; i < RD_LAT; i++) dp[i] <= dp[i-1];
  end

  assign mem_rdata_in = dp[RD_LAT-1];

  int         cyc, n_checks, n_fail, n_acc;
  logic       fs_m, pend_m, run_m;
  logic [7:0] pix_hold;
  hist_t      hist[$];
  rd_t        rdq[$];
  logic [7:0] shadow [int];

  function automatic logic [7:0] pat(input int a);
    int v;
    v = (a * 29) ^ (a >> 7);
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_val(input logic [16:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : pat(int'(a));
  endfunction

  function automatic logic [16:0] vaddr(input logic fs, input logic [9:0] vc, input logic [10:0] hc);
    return 17'((fs ? FB_SZ : 0) + (int'(vc) / 4) * 320 + int'(hc) / 4);
  endfunction

  function automatic logic [16:0] caddr(input logic fs, input logic [15:0] a);
    return 17'((fs ? 0 : FB_SZ) + int'(a));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 64'({pix_out, ad_out, hs_out, vs_out, cl_ready_out, cl_rvalid_out, cl_rdata_out,
                    swap_done_out, front_sel_out, mem_addr_out, mem_we_out, mem_wdata_out}), 64'd0);
  endtask

  task automatic quiet_inputs();
    hcount_in = '0; vcount_in = '0; ad_in = 0; hs_in = 0; vs_in = 0; nf_in = 0;
    cl_valid_in = 0; cl_we_in = 0; cl_addr_in = '0; cl_wdata_in = '0; swap_req_in = 0;
  endtask

  task automatic rand_inputs();
    hcount_in = 11'($urandom); vcount_in = 10'($urandom); ad_in = 1'($urandom);
    hs_in = 1'($urandom); vs_in = 1'($urandom); nf_in = 1'($urandom);
    cl_valid_in = 1'($urandom); cl_we_in = 1'($urandom); cl_addr_in = 16'($urandom);
    cl_wdata_in = 8'($urandom); swap_req_in = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst_n_in = 1'b0;
    hist.delete(); rdq.delete();
    fs_m = 0; pend_m = 0; run_m = 0; pix_hold = 8'h00;
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      #1 check_zero("rst_hold");
      @(posedge clk_pixel_in); cyc++; #1;
    end
    check_zero("rst_edge");
    rst_n_in = 1'b1;
    quiet_inputs();
    #1 check_zero("rst_release");
  endtask

  // One clock cycle: inputs must already be applied (1 time unit after an edge).
  task automatic step();
    logic        slot, rdy_e, acc, oor, we_l, done_e;
    logic [16:0] a_e;
    logic [7:0]  wd_l;
    hist_t       h;
    rd_t         r;
    #1;
    slot  = ad_in && (hcount_in[1:0] == 2'd0);
    rdy_e = run_m && !slot;
    check("cl_ready", 64'(cl_ready_out), 64'(rdy_e));
    if (cl_valid_in && cl_ready_out) n_acc++;
    acc  = cl_valid_in && rdy_e;
    we_l = cl_we_in;
    wd_l = cl_wdata_in;
    oor  = int'(cl_addr_in) >= FB_SZ;
    a_e  = slot ? vaddr(fs_m, vcount_in, hcount_in) : caddr(fs_m, cl_addr_in);
    h = '{ad_in, hs_in, vs_in, slot, slot ? exp_val(a_e) : 8'h00};
    hist.push_back(h);
    if (acc && !we_l) begin
      r.due  = cyc + LAT;
      r.data = oor ? 8'h00 : exp_val(a_e);
      rdq.push_back(r);
    end
    if (acc && we_l && !oor) shadow[int'(a_e)] = wd_l;
    done_e = 0;
    if (!pend_m) begin
      if (swap_req_in && nf_in) begin fs_m = !fs_m; done_e = 1; end
      else if (swap_req_in) pend_m = 1;
    end else if (nf_in) begin
      pend_m = 0; fs_m = !fs_m; done_e = 1;
    end

    @(posedge clk_pixel_in); cyc++; run_m = 1; #1;

    if (slot) begin
      check("vid_addr", 64'(mem_addr_out), 64'(a_e));
      check("vid_we", 64'(mem_we_out), 64'd0);
    end else if (acc) begin
      check("cl_we", 64'(mem_we_out), 64'(we_l && !oor));
      if (!oor) check("cl_addr", 64'(mem_addr_out), 64'(a_e));
      if (we_l && !oor) check("cl_wdata", 64'(mem_wdata_out), 64'(wd_l));
    end else begin
      check("idle_we", 64'(mem_we_out), 64'd0);
    end

    if (hist.size() == LAT) begin
      h = hist.pop_front();
      if (h.slot) pix_hold = h.val;
    end else begin
      h = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    end
    check("ad_out", 64'(ad_out), 64'(h.ad));
    check("hs_out", 64'(hs_out), 64'(h.hs));
    check("vs_out", 64'(vs_out), 64'(h.vs));
    check("pix_out", 64'(pix_out), 64'(h.ad ? pix_hold : 8'h00));

    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      check("rvalid", 64'(cl_rvalid_out), 64'd1);
      if (cl_rvalid_out) check("rdata", 64'(cl_rdata_out), 64'(r.data));
    end else begin
      check("rvalid_idle", 64'(cl_rvalid_out), 64'd0);
    end

    check("swap_done", 64'(swap_done_out), 64'(done_e));
    check("front_sel", 64'(front_sel_out), 64'(fs_m));
  endtask

  task automatic client(input logic we, input logic [15:0] a, input logic [7:0] wd);
    cl_valid_in = 1; cl_we_in = we; cl_addr_in = a; cl_wdata_in = wd;
    step();
    cl_valid_in = 0;
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = pat(i);
    for (int i = 0; i < RD_LAT; i++) dp[i] = 8'h00;
    cyc = 0; n_checks = 0; n_fail = 0; n_acc = 0;
    quiet_inputs();
    #2;
    do_reset(5);
    check("rst_front_sel", 64'(front_sel_out), 64'd0);
    repeat (3) step();

    // Video fetch at vcount 8: one read per 4 pixels, pixel replicated 4x.
    vcount_in = 10'd8; ad_in = 1;
    for (int h = 0; h < 8; h++) begin
      hcount_in = 11'(h); hs_in = (h == 2); vs_in = (h == 5);
      step();
      if (h == 0) check("fetch_640", 64'(mem_addr_out), 64'd640);
      if (h == 4) check("fetch_641", 64'(mem_addr_out), 64'd641);
    end
    ad_in = 0; hs_in = 0; vs_in = 0;
    for (int h = 8; h < 14; h++) begin hcount_in = 11'(h); step(); end

    // Contention: active video blocks every 4th request, blanking blocks none.
    vcount_in = 10'd12; ad_in = 1; cl_valid_in = 1; cl_we_in = 1; n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      hcount_in = 11'(i); cl_addr_in = 16'(200 + i); cl_wdata_in = 8'(i); step();
    end
    check("acc_active", 64'(n_acc), 64'd12);
    ad_in = 0; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      hcount_in = 11'(16 + i); cl_addr_in = 16'(300 + i); cl_wdata_in = 8'(i + 64); step();
    end
    check("acc_blank", 64'(n_acc), 64'd8);
    cl_valid_in = 0;

    // Client write then read-back through the back buffer.
    client(1, 16'd100, 8'hA5);
    check("wr_addr_57700", 64'(mem_addr_out), 64'd57700);
    check("wr_data_a5", 64'(mem_wdata_out), 64'hA5);
    client(0, 16'd100, 8'h00);
    repeat (6) step();
    check("rd_a5", 64'(cl_rdata_out), 64'hA5);

    // Out-of-range index and the last valid index.
    client(1, 16'd57600, 8'h3C);
    check("oor_no_we", 64'(mem_we_out), 64'd0);
    client(0, 16'd57600, 8'h00);
    repeat (6) step();
    check("oor_rdata0", 64'(cl_rdata_out), 64'd0);
    client(1, 16'd57599, 8'h5A);
    check("last_addr", 64'(mem_addr_out), 64'd115199);
    client(0, 16'd57599, 8'h00);
    repeat (6) step();
    check("last_rd", 64'(cl_rdata_out), 64'h5A);

    // Swap: request mid-frame, duplicate while pending, then nf.
    swap_req_in = 1; step(); swap_req_in = 0;
    repeat (3) step();
    swap_req_in = 1; step(); swap_req_in = 0; step();
    nf_in = 1; step(); nf_in = 0;
    check("swap_fs1", 64'(front_sel_out), 64'd1);
    check("swap_done1", 64'(swap_done_out), 64'd1);
    repeat (2) step();
    nf_in = 1; step(); nf_in = 0;
    check("no_double_toggle", 64'(front_sel_out), 64'd1);
    client(1, 16'd100, 8'h77);
    check("back0_addr", 64'(mem_addr_out), 64'd100);
    swap_req_in = 1; nf_in = 1; step(); swap_req_in = 0; nf_in = 0;
    check("swap_now", 64'(front_sel_out), 64'd0);
    step();

    // Reset with a read in flight: no response may appear.
    client(0, 16'd100, 8'h00);
    step();
    do_reset(3);
    repeat (8) step();

    // Mixed traffic over a few scan lines.
    for (int k = 0; k < 384; k++) begin
      hcount_in   = 11'(k % 64);
      vcount_in   = 10'((k / 64) * 4 + 8);
      ad_in       = (k % 64) < 44;
      hs_in       = (k % 64) >= 50 && (k % 64) < 56;
      vs_in       = (k / 64) == 3;
      nf_in       = (k % 64) == 60 && ((k / 64) % 2) == 1;
      swap_req_in = $urandom_range(0, 15) == 0;
      cl_valid_in = 1'($urandom);
      cl_we_in    = 1'($urandom);
      cl_addr_in  = ($urandom_range(0, 7) == 0) ? 16'(57590 + $urandom_range(0, 20))
                                                : 16'($urandom_range(0, 600));
      cl_wdata_in = 8'($urandom);
      step();
    end
    quiet_inputs();
    repeat (8) step();
    check("drain", 64'(rdq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
